// File: rtl/timer_pkg.sv
// Shared constants for the microwave countdown timer digits.
//   DIGIT_W        width of one BCD digit register
//   SEC_UNITS_MAX  wrap value of the units-of-seconds digit
//   SEC_TENS_MAX   wrap value of the tens-of-seconds digit
package timer_pkg;
  localparam int DIGIT_W       = 4;
  localparam int SEC_UNITS_MAX = 9;
  localparam int SEC_TENS_MAX  = 5;
endpackage

// File: rtl/timer_ten.sv
// Single BCD down-counting timer digit with preset load, borrow out and zero flag.
// Counts MAX_DIGIT..0 and wraps back to MAX_DIGIT; tc is the borrow into the
// next-higher digit and is high during the cycle whose edge performs the wrap.
//
// Ports:
//   data   in  [WIDTH-1:0]  preset value, loaded while loadn=0
//   loadn  in               synchronous load, active-low (beats en)
//   clk    in               clock, rising edge
//   clrn   in               asynchronous clear, active-low
//   en     in               count enable
//   ones   out [WIDTH-1:0]  current digit value
//   tc     out              borrow: (ones==0) & en & loadn
//   zero   out              ones==0
//
// Build option: define TIMER_TEN_LOAD_CLAMP_EN to saturate loaded values
// above MAX_DIGIT to MAX_DIGIT; otherwise data is loaded verbatim.
module timer_ten
  import timer_pkg::*;
#(
  parameter int MAX_DIGIT = SEC_UNITS_MAX,
  parameter int WIDTH     = DIGIT_W
) (
  input  logic [WIDTH-1:0] data,
  input  logic             loadn,
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  output logic [WIDTH-1:0] ones,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_DIGIT);

  logic [WIDTH-1:0] load_val;

`ifdef TIMER_TEN_LOAD_CLAMP_EN
  assign load_val = (data > MAX_V) ? MAX_V : data;
`else
  assign load_val = data;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ones <= '0;
    end else if (!loadn) begin
      ones <= load_val;
    end else if (en) begin
      ones <= (ones == '0) ? MAX_V : ones - WIDTH'(1);
    end
  end

  assign zero = (ones == '0);
  // Borrow is suppressed during a load so a reloading digit never clocks its neighbour.
  assign tc   = zero & en & loadn;

endmodule

// File: tb/tb_timer_ten.sv
module tb_timer_ten;
  logic       clk = 1'b0;
  logic       clrn;
  logic       loadn;
  logic       en;
  logic [3:0] data;
  logic [3:0] ones9, ones5;
  logic       tc9, tc5, zero9, zero5;

  int n_pass = 0;
  int n_checks = 0;

  int m_cnt [2];
  int maxv  [2] = '{9, 5};

`ifdef TIMER_TEN_LOAD_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  always #10 clk = ~clk;

  timer_ten #(.MAX_DIGIT(9), .WIDTH(4)) dut9 (
    .data(data), .loadn(loadn), .clk(clk), .clrn(clrn), .en(en),
    .ones(ones9), .tc(tc9), .zero(zero9)
  );

  timer_ten #(.MAX_DIGIT(5), .WIDTH(4)) dut5 (
    .data(data), .loadn(loadn), .clk(clk), .clrn(clrn), .en(en),
    .ones(ones5), .tc(tc5), .zero(zero5)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: the digit value as an integer, following the stated rules.
  always @(posedge clk or negedge clrn) begin
    for (int i = 0; i < 2; i++) begin
      if (!clrn) m_cnt[i] <= 0;
      else if (!loadn) begin
        if (CLAMP && int'(data) > maxv[i]) m_cnt[i] <= maxv[i];
        else m_cnt[i] <= int'(data);
      end else if (en) m_cnt[i] <= (m_cnt[i] == 0) ? maxv[i] : m_cnt[i] - 1;
    end
  end

  always @(negedge clk) begin
    chk("ones9", int'(ones9), m_cnt[0]);
    chk("zero9", int'(zero9), int'(m_cnt[0] == 0));
    chk("tc9",   int'(tc9),   int'(m_cnt[0] == 0 && en && loadn));
    chk("ones5", int'(ones5), m_cnt[1]);
    chk("zero5", int'(zero5), int'(m_cnt[1] == 0));
    chk("tc5",   int'(tc5),   int'(m_cnt[1] == 0 && en && loadn));
  end

  // Advance n rising edges, then settle 5 units past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  initial begin
    clrn = 1'b0; loadn = 1'b1; en = 1'b0; data = 4'd0;
    step(2);
    chk("rst_ones", int'(ones9), 0);
    chk("rst_zero", int'(zero9), 1);
    chk("rst_tc",   int'(tc9),   0);
    clrn = 1'b1;

    // Load 7 (held over two edges) then count down to 0
    data = 4'd7; loadn = 1'b0; en = 1'b1;
    step(2);
    chk("load7", int'(ones9), 7);
    loadn = 1'b1;
    for (int k = 6; k >= 0; k--) begin
      step(1);
      chk("down", int'(ones9), k);
      chk("down_zero", int'(zero9), int'(k == 0));
    end

    // Wrap 0 -> 9
    chk("wrap_tc_hi", int'(tc9), 1);
    step(1);
    chk("wrap_ones", int'(ones9), 9);
    chk("wrap_tc_lo", int'(tc9), 0);
    chk("wrap_zero", int'(zero9), 0);

    // Hold at 4
    step(5);
    chk("at4", int'(ones9), 4);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("hold", int'(ones9), 4);
      chk("hold_tc", int'(tc9), 0);
    end

    // Load beats enable
    en = 1'b1;
    step(1);
    chk("at3", int'(ones9), 3);
    loadn = 1'b0; data = 4'd8;
    chk("ld_tc", int'(tc9), 0);
    step(1);
    chk("ld_prio", int'(ones9), 8);

    // Out-of-range load
    data = 4'd12;
    step(1);
    chk("clamp9", int'(ones9), CLAMP ? 9 : 12);
    chk("clamp5", int'(ones5), CLAMP ? 5 : 12);
    loadn = 1'b1;
    step(1);
    chk("after_clamp9", int'(ones9), CLAMP ? 8 : 11);

    // MAX_DIGIT=5 wrap
    loadn = 1'b0; data = 4'd1;
    step(1);
    loadn = 1'b1;
    step(1);
    chk("d5_zero", int'(ones5), 0);
    chk("d5_tc", int'(tc5), 1);
    step(1);
    chk("d5_wrap", int'(ones5), 5);
    chk("d9_wrap", int'(ones9), 9);

    // Asynchronous clear mid-count, no clock edge needed
    step(3);
    clrn = 1'b0;
    #1;
    chk("async_ones9", int'(ones9), 0);
    chk("async_zero9", int'(zero9), 1);
    chk("async_ones5", int'(ones5), 0);
    chk("async_tc9",   int'(tc9),   1);
    step(1);
    clrn = 1'b1;
    step(2);
    chk("post_rst", int'(ones9), 8);

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
